ram_port_master: RTL and testbench

RAM_PORT_MASTER -- requirements
Module: ram_port_master

---
 rtl/ram_port_master_pkg.sv | 13 +
 rtl/ram_rsp_fifo.sv | 52 +++++
 rtl/ram_port_master.sv | 107 ++++++++++
 tb/tb_ram_port_master.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_master_pkg.sv
// ram_port_master_pkg -- shared types and constants for ram_port_master.
//   state_e        : top-level FSM state (CLEAR sweeps the RAM, RUN serves requests)
//   RSP_FIFO_DEPTH : depth of the read-response buffer
package ram_port_master_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int RSP_FIFO_DEPTH = 2;

endpackage

// File: rtl/ram_rsp_fifo.sv
// ram_rsp_fifo -- 2-entry response FIFO, storage reset to zero.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   push, din  : write one entry (caller guarantees not full unless popping)
//   pop        : drop the head (caller guarantees not empty)
//   dout       : head entry
//   count      : occupancy 0..2
module ram_rsp_fifo
  import ram_port_master_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            count
);

  logic [RSP_FIFO_DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic                                      rd_ptr;
  logic                                      wr_ptr;
  logic [1:0]                                cnt_r;

  // With two slots, a full FIFO has wr_ptr == rd_ptr; a simultaneous
  // push+pop writes into the slot being vacated, which becomes the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt_r  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt_r <= cnt_r + 2'd1;
        2'b01:   cnt_r <= cnt_r - 2'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign count = cnt_r;

endmodule

// File: rtl/ram_port_master.sv
// ram_port_master -- request/response front end for a single-port RAM with
// registered read address (RAM_Q valid the cycle after the address).
// Optional clear sweep: define RAM_PORT_MASTER_CLEAR_EN to zero all RAM_DEPTH
// words after every reset before requests are accepted.
// Ports:
//   CLK, RST                          : clock, async active-low reset
//   REQ_VALID/READY/WE/ADDR/D         : request channel (write or read)
//   RSP_VALID/READY, RSP_Q            : in-order read responses
//   RAM_ADDR/D/WE, RAM_Q              : RAM port
//   BUSY                              : clear sweep in progress
module ram_port_master
  import ram_port_master_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WE,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_D,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_Q,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR,
  output logic [DATA_WIDTH-1:0] RAM_D,
  output logic                  RAM_WE,
  input  logic [DATA_WIDTH-1:0] RAM_Q,
  output logic                  BUSY
);

  logic       run;
  logic       rd_pending;
  logic       rd_ok;
  logic       rd_acc;
  logic       pop;
  logic [1:0] fifo_count;

`ifdef RAM_PORT_MASTER_CLEAR_EN
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(RAM_DEPTH - 1);

  state_e                state;
  logic [ADDR_WIDTH-1:0] clr_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      if (clr_cnt == CLR_LAST) state <= RUN;
      else                     clr_cnt <= clr_cnt + 1'b1;
    end
  end

  assign run  = (state == RUN);
  assign BUSY = (state == CLEAR);
`else
  assign run  = 1'b1;
  assign BUSY = 1'b0;
`endif

  assign RSP_VALID = (fifo_count != 2'd0);
  assign pop       = RSP_VALID & RSP_READY;

  // Reserve a FIFO slot for every read in flight; a pop this cycle frees one,
  // hence the combinational RSP_READY -> REQ_READY path.
  assign rd_ok = ({1'b0, fifo_count} + {2'b00, rd_pending}) < (3'd2 + {2'b00, pop});

  // RST gates the handshake so nothing is accepted while reset is held.
  assign REQ_READY = RST & run & (REQ_WE | rd_ok);
  assign rd_acc    = REQ_VALID & REQ_READY & ~REQ_WE;

  always_comb begin
    RAM_ADDR = REQ_ADDR;
    RAM_D    = REQ_D;
    RAM_WE   = REQ_VALID & REQ_READY & REQ_WE;
`ifdef RAM_PORT_MASTER_CLEAR_EN
    if (!run) begin
      RAM_ADDR = clr_cnt;
      RAM_D    = '0;
      RAM_WE   = RST;
    end
`endif
  end

  // One-stage read valid pipe: RAM_Q carries the data the cycle after accept.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) rd_pending <= 1'b0;
    else      rd_pending <= rd_acc;
  end

  ram_rsp_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk  (CLK),
    .rst_n(RST),
    .push (rd_pending),
    .din  (RAM_Q),
    .pop  (pop),
    .dout (RSP_Q),
    .count(fifo_count)
  );

endmodule

// File: tb/tb_ram_port_master.sv
module tb_ram_port_master;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          REQ_VALID, REQ_READY, REQ_WE;
  logic [AW-1:0] REQ_ADDR;
  logic [DW-1:0] REQ_D;
  logic          RSP_VALID, RSP_READY;
  logic [DW-1:0] RSP_Q;
  logic [AW-1:0] RAM_ADDR;
  logic [DW-1:0] RAM_D;
  logic          RAM_WE;
  logic [DW-1:0] RAM_Q;
  logic          BUSY;

  ram_port_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR), .REQ_D(REQ_D),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_Q(RSP_Q),
    .RAM_ADDR(RAM_ADDR), .RAM_D(RAM_D), .RAM_WE(RAM_WE), .RAM_Q(RAM_Q),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // RAM with registered read: RAM_Q reflects the address of the previous edge.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge CLK) begin
    if (RAM_WE) ram[RAM_ADDR] <= RAM_D;
    RAM_Q <= ram[RAM_ADDR];
  end

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] sb[$];
  int            rsp_cyc[$];
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: inputs change #1 after posedge, so values at negedge are what
  // the next posedge will sample.
  always @(negedge CLK) begin
    if (REQ_VALID && REQ_READY) begin
      if (REQ_WE) model[REQ_ADDR] = REQ_D;
      else        sb.push_back(model[REQ_ADDR]);
    end
    if (RSP_VALID && RSP_READY) begin
      if (sb.size() == 0) chk("spurious_rsp", 32'(RSP_Q), 32'hFFFF_FFFF);
      else                chk("rsp", 32'(RSP_Q), 32'(sb.pop_front()));
      rsp_cyc.push_back(cyc);
    end
  end

  task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = a; REQ_D = d;
    @(negedge CLK);
    chk("wr_rdy", 32'(REQ_READY), 1);
    chk("wr_ramwe", 32'(RAM_WE), 1);
    chk("wr_ramaddr", 32'(RAM_ADDR), 32'(a));
    @(posedge CLK); #1;
    REQ_VALID = 1'b0; REQ_WE = 1'b0;
  endtask

  task automatic do_rd(input logic [AW-1:0] a, output int waited);
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = a;
    waited = 0;
    @(negedge CLK);
    while (!REQ_READY && waited < 64) begin
      waited++;
      @(negedge CLK);
    end
    if (!REQ_READY) chk("rd_timeout", 0, 1);
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge CLK);
    chk("drain", sb.size(), 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && BUSY; i++) @(negedge CLK);
    chk("busy_done", 32'(BUSY), 0);
  endtask

  initial begin
    int w, n0;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = DW'(8'h40 + i);
`ifdef RAM_PORT_MASTER_CLEAR_EN
      model[i] = '0;
`else
      model[i] = DW'(8'h40 + i);
`endif
    end
    RST = 1'b0; REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 4'd2; REQ_D = 8'h77;
    RSP_READY = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_req_ready", 32'(REQ_READY), 0);
    chk("rst_rsp_valid", 32'(RSP_VALID), 0);
    chk("rst_rsp_q", 32'(RSP_Q), 0);
    chk("rst_ram_we", 32'(RAM_WE), 0);
`ifdef RAM_PORT_MASTER_CLEAR_EN
    chk("rst_busy", 32'(BUSY), 1);
`else
    chk("rst_busy", 32'(BUSY), 0);
`endif
    REQ_VALID = 1'b0; REQ_WE = 1'b0;
    @(posedge CLK); #1 RST = 1'b1;

`ifdef RAM_PORT_MASTER_CLEAR_EN
    REQ_VALID = 1'b1;  // pending read must be held off during the sweep
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge CLK);
      chk("clr_busy", 32'(BUSY), 1);
      chk("clr_ready", 32'(REQ_READY), 0);
      chk("clr_we", 32'(RAM_WE), 1);
      chk("clr_addr", 32'(RAM_ADDR), i);
      chk("clr_d", 32'(RAM_D), 0);
    end
    REQ_VALID = 1'b0;
    @(negedge CLK);
    chk("clr_end_busy", 32'(BUSY), 0);
    @(posedge CLK); #1;
    do_rd(4'd5, w);
    wait_drain();
`else
    @(negedge CLK);
    chk("run_busy", 32'(BUSY), 0);
    chk("run_ready", 32'(REQ_READY), 1);
    @(posedge CLK); #1;
`endif

    // Read latency and read-after-write.
    do_wr(4'd3, 8'hA5);
    do_rd(4'd3, w);
    @(negedge CLK);
    chk("lat_t1_valid", 32'(RSP_VALID), 0);
    @(negedge CLK);
    chk("lat_t2_valid", 32'(RSP_VALID), 1);
    chk("lat_t2_q", 32'(RSP_Q), 32'hA5);
    wait_drain();
    @(posedge CLK); #1;

    // Back-pressure: third read is refused, writes still go through.
    RSP_READY = 1'b0;
    do_rd(4'd1, w); chk("bp_rd1_wait", w, 0);
    do_rd(4'd2, w); chk("bp_rd2_wait", w, 0);
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 4'd3;
    @(negedge CLK);
    chk("bp_rd3_ready", 32'(REQ_READY), 0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("bp_full_ready", 32'(REQ_READY), 0);
    chk("bp_full_valid", 32'(RSP_VALID), 1);
    chk("bp_head", 32'(RSP_Q), 32'(model[1]));
    @(posedge CLK); #1;
    do_wr(4'd7, 8'h3C);
    @(negedge CLK);
    chk("bp_hold", 32'(RSP_Q), 32'(model[1]));
    @(posedge CLK); #1;
    RSP_READY = 1'b1;
    do_rd(4'd3, w);
    do_rd(4'd7, w);
    wait_drain();
    @(posedge CLK); #1;

    // Streaming 8 reads of freshly written data.
    for (int i = 8; i < 16; i++) do_wr(AW'(i), DW'(i * 3 + 7));
    n0 = rsp_cyc.size();
    for (int i = 8; i < 16; i++) begin
      do_rd(AW'(i), w);
      chk("strm_wait", w, 0);
    end
    wait_drain();
    chk("strm_count", rsp_cyc.size() - n0, 8);
    if (rsp_cyc.size() >= n0 + 8) chk("strm_span", rsp_cyc[n0+7] - rsp_cyc[n0], 7);
    @(posedge CLK); #1;

    // Reset with two responses buffered.
    RSP_READY = 1'b0;
    do_rd(4'd1, w);
    do_rd(4'd2, w);
    @(negedge CLK);
    @(negedge CLK);
    chk("mr_buffered", 32'(RSP_VALID), 1);
    #2 RST = 1'b0;
    sb.delete();
`ifdef RAM_PORT_MASTER_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
`endif
    #1;
    chk("mr_valid_async", 32'(RSP_VALID), 0);
    chk("mr_q", 32'(RSP_Q), 0);
    chk("mr_ready", 32'(REQ_READY), 0);
    RSP_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("mr_stale", 32'(RSP_VALID), 0);
    end
    @(posedge CLK); #1;
    do_rd(4'd9, w);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1);
  end
endmodule
